spi_byte_bridge: RTL
====================

Name: spi_byte_bridge

Overview:
- Memory-mapped front end that sits directly upstream of the SPI byte controller. It feeds that controller's start/command inputs and consumes its response and BSY status.
- The CPU writes command bytes into a TX FIFO. The bridge runs one SPI byte transfer per entry and pushes each received response byte into an RX FIFO, which the CPU reads.
- Status and control registers expose FIFO levels, sticky error flags and an optional interrupt.

Parameters:
- DEPTH, 4, entries per FIFO; power of two, minimum 2.
- BSY_TIMEOUT, 16, clocks to wait for spi_busy to rise after spi_start before aborting.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  asynchronous, active-low reset. Asserting low resets all state immediately; release is synchronous to clk.
- bus_wr  input  1  register write strobe, one cycle.
- bus_rd  input  1  register read strobe, one cycle.
- bus_addr  input  2  0=DATA, 1=STATUS, 2=CTRL, 3=reserved.
- bus_wdata  input  8  write data.
- bus_rdata  output  8  read data, combinational from bus_addr. A pop side effect takes place at the clk edge on which bus_rd is high.
- spi_start  output  1  one-cycle start pulse to the SPI controller.
- spi_command  output  8  byte to shift out; stable from the spi_start cycle until the transfer completes.
- spi_response  input  8  controller's received byte.
- spi_busy  input  1  controller BSY (csr bit 0).
- irq  output  1  interrupt, level-sensitive.

Behaviour:
- Reset values:
  - spi_start=0, spi_command=0, irq=0.
  - Both FIFOs empty; all sticky flags 0; CTRL=0; FSM in IDLE.
  - bus_rdata reflects the reset register contents.
- DATA register:
  - Write pushes bus_wdata into TX. If TX is full, the byte is dropped and tx_ovf is set.
  - Read returns the RX head and pops it. If RX is empty, the read returns 0x00, nothing pops, and rx_unf is set.
- STATUS register (read-only), bits [7:0] = {err_to, rx_unf, tx_ovf, xfer_active, rx_full, rx_empty, tx_full, tx_empty}.
- CTRL register:
  - bit0 EN: transfers start only when EN=1.
  - bit1 IRQ_EN.
  - Writing with bit7=1 clears all sticky flags; bit7 always reads 0.
  - Other bits read 0.
- FSM states: IDLE, START, WAIT_BSY, WAIT_DONE, CAPTURE.
  - IDLE: if EN && !tx_empty && !rx_full, latch the TX head into spi_command, pop TX, go to START. The transfer stalls (stays in IDLE) while RX is full, so no response is ever lost.
  - START: spi_start=1 for exactly this cycle; clear the timeout counter; go to WAIT_BSY.
  - WAIT_BSY: on spi_busy=1, go to WAIT_DONE. Otherwise increment the counter. When the counter reaches BSY_TIMEOUT-1, set err_to, discard the byte and return to IDLE.
  - WAIT_DONE: on spi_busy=0, go to CAPTURE.
  - CAPTURE: push spi_response into RX (space is guaranteed by the IDLE check); go to IDLE.
- xfer_active = (state != IDLE).
- Latency: a DATA write on edge N into an empty TX with EN=1 and the FSM in IDLE gives START state after edge N+1, so spi_start is high during cycle N+1..N+2.
- Simultaneous events:
  - A TX push and an FSM pop in the same cycle are both honoured; the count is unchanged.
  - An RX pop (CPU read) and a CAPTURE push in the same cycle are both honoured.
- Clearing EN mid-transfer: the current byte completes and is captured; no further bytes start.
- Reset asserted mid-transfer: everything returns to reset values immediately. spi_start drops to 0, and any partially received byte is lost.
- FIFO pointers are log2(DEPTH) bits plus one wrap bit.
  - Full = pointers equal except the wrap bit.
  - Empty = pointers fully equal.

Optional Feature:
- SPI_BRIDGE_IRQ_EN
  - Defined: irq = IRQ_EN && (!rx_empty || err_to), registered (one cycle after the condition), cleared on reset.
  - Undefined: irq is tied to 0, and CTRL bit1 is not stored and reads 0.

Test Plan:
- Single byte:
  - Stimulus: EN=1, write DATA=0xA5; model the controller with busy high for 8 clocks and response=0x3C.
  - Required: exactly one spi_start pulse with spi_command=0xA5; after busy falls, STATUS rx_empty=0; a DATA read returns 0x3C, then rx_empty=1.
- Burst and backpressure:
  - Stimulus: DEPTH=4; write 5 bytes 0x01..0x05 with EN=0.
  - Required: tx_full=1 and tx_ovf=1 after the 5th write. Then set EN=1 and do not read RX: 4 transfers run, RX becomes full, and the FSM stays in IDLE. Reading one RX byte (0x01's response) causes no new start, because TX is empty.
- Timeout:
  - Stimulus: EN=1, write 0x55, hold spi_busy=0.
  - Required: err_to=1 exactly BSY_TIMEOUT clocks after the spi_start cycle; RX stays empty; a CTRL write with 0x81 clears err_to and keeps EN=1.
- Underflow:
  - Stimulus: read DATA with RX empty.
  - Required: rdata=0x00, rx_unf=1, FIFO pointers unchanged.
- Reset mid-transfer:
  - Stimulus: pull rst low while in WAIT_DONE with 2 bytes left in TX.
  - Required: spi_start=0, tx_empty=1, rx_empty=1, flags=0, CTRL=0 immediately. After release, no spi_start occurs without a new write.
- IRQ:
  - Stimulus: with SPI_BRIDGE_IRQ_EN defined and IRQ_EN=1, complete one transfer.
  - Required: irq rises one cycle after rx_empty falls and drops one cycle after the RX pop. Without the macro, irq stays 0 throughout.

Source files
------------

// File: rtl/spi_byte_bridge.sv
// spi_byte_bridge: CPU register front end with TX/RX byte FIFOs feeding an SPI byte controller.
// Define SPI_BRIDGE_IRQ_EN to build the registered level interrupt and the CTRL IRQ_EN bit.

module spi_bridge_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [DEPTH-1:0][W-1:0] mem;
  logic [AW:0]             wp, rp;

  // Extra wrap bit distinguishes full from empty when the index bits match.
  assign empty = (wp == rp);
  assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign dout  = mem[rp[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp  <= '0;
      rp  <= '0;
      mem <= '0;
    end else begin
      if (push) begin
        mem[wp[AW-1:0]] <= din;
        wp              <= wp + PTR_ONE;
      end
      if (pop) rp <= rp + PTR_ONE;
    end
  end
endmodule

module spi_byte_bridge #(
  parameter int DEPTH       = 4,
  parameter int BSY_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bus_wr,
  input  logic       bus_rd,
  input  logic [1:0] bus_addr,
  input  logic [7:0] bus_wdata,
  output logic [7:0] bus_rdata,
  output logic       spi_start,
  output logic [7:0] spi_command,
  input  logic [7:0] spi_response,
  input  logic       spi_busy,
  output logic       irq
);
  typedef enum logic [2:0] {IDLE, START, WAIT_BSY, WAIT_DONE, CAPTURE} state_t;

  localparam int CW = (BSY_TIMEOUT > 2) ? $clog2(BSY_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BSY_TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [1:0] A_DATA = 2'd0, A_STAT = 2'd1, A_CTRL = 2'd2;

  state_t        state, state_d;
  logic [CW-1:0] cnt;
  logic          en, irq_en, err_to, rx_unf, tx_ovf;
  logic          tx_full, tx_empty, rx_full, rx_empty;
  logic [7:0]    tx_dout, rx_dout;
  logic          data_wr, data_rd, ctrl_wr;
  logic          tx_push, tx_pop, rx_push, rx_pop, to_hit;

  assign data_wr = bus_wr && (bus_addr == A_DATA);
  assign data_rd = bus_rd && (bus_addr == A_DATA);
  assign ctrl_wr = bus_wr && (bus_addr == A_CTRL);
  assign tx_push = data_wr && !tx_full;
  assign rx_pop  = data_rd && !rx_empty;

  spi_bridge_fifo #(.DEPTH(DEPTH), .W(8)) u_tx (
    .clk(clk), .rst(rst), .push(tx_push), .pop(tx_pop), .din(bus_wdata),
    .dout(tx_dout), .full(tx_full), .empty(tx_empty)
  );

  spi_bridge_fifo #(.DEPTH(DEPTH), .W(8)) u_rx (
    .clk(clk), .rst(rst), .push(rx_push), .pop(rx_pop), .din(spi_response),
    .dout(rx_dout), .full(rx_full), .empty(rx_empty)
  );

  // A transfer only launches with RX space free, so CAPTURE can always push.
  always_comb begin
    state_d = state;
    tx_pop  = 1'b0;
    rx_push = 1'b0;
    to_hit  = 1'b0;
    case (state)
      IDLE:      if (en && !tx_empty && !rx_full) begin
                   tx_pop  = 1'b1;
                   state_d = START;
                 end
      START:     state_d = WAIT_BSY;
      WAIT_BSY:  if (spi_busy) state_d = WAIT_DONE;
                 else if (cnt == CNT_LAST) begin
                   to_hit  = 1'b1;
                   state_d = IDLE;
                 end
      WAIT_DONE: if (!spi_busy) state_d = CAPTURE;
      CAPTURE:   begin
                   rx_push = 1'b1;
                   state_d = IDLE;
                 end
      default:   state_d = IDLE;
    endcase
  end

  assign spi_start = (state == START);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      spi_command <= '0;
    end else begin
      state <= state_d;
      if (tx_pop) spi_command <= tx_dout;
      if (state == START)         cnt <= '0;
      else if (state == WAIT_BSY) cnt <= cnt + CNT_ONE;
    end
  end

  // Sticky flags: a same-cycle set beats a CTRL clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en     <= 1'b0;
      err_to <= 1'b0;
      rx_unf <= 1'b0;
      tx_ovf <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        en <= bus_wdata[0];
        if (bus_wdata[7]) begin
          err_to <= 1'b0;
          rx_unf <= 1'b0;
          tx_ovf <= 1'b0;
        end
      end
      if (to_hit)              err_to <= 1'b1;
      if (data_rd && rx_empty) rx_unf <= 1'b1;
      if (data_wr && tx_full)  tx_ovf <= 1'b1;
    end
  end

`ifdef SPI_BRIDGE_IRQ_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      irq_en <= 1'b0;
      irq    <= 1'b0;
    end else begin
      if (ctrl_wr) irq_en <= bus_wdata[1];
      irq <= irq_en && (!rx_empty || err_to);
    end
  end
`else
  assign irq_en = 1'b0;
  assign irq    = 1'b0;
`endif

  always_comb begin
    bus_rdata = 8'h00;
    case (bus_addr)
      A_DATA:  bus_rdata = rx_empty ? 8'h00 : rx_dout;
      A_STAT:  bus_rdata = {err_to, rx_unf, tx_ovf, state != IDLE,
                            rx_full, rx_empty, tx_full, tx_empty};
      A_CTRL:  bus_rdata = {6'b0, irq_en, en};
      default: bus_rdata = 8'h00;
    endcase
  end
endmodule
